// File: rtl/jt12_decim_ctrl_if.sv
// Configuration, strobe and sample-handshake signals of the decimator controller.
// The controller connects through the slave modport; the driving side uses master.
interface jt12_decim_ctrl_if #(
  parameter int unsigned DIVW  = 8,
  parameter int unsigned RATEW = 4
);
  logic             enable;
  logic             cfg_we;
  logic [DIVW-1:0]  cfg_div;
  logic [RATEW-1:0] cfg_rate;
  logic             out_ack;
  logic             ovr_clr;
  logic             cen_in;
  logic             cen_out;
  logic [RATEW-1:0] phase;
  logic             out_valid;
  logic             overrun;
  logic             busy;

  modport slave (
    input  enable, cfg_we, cfg_div, cfg_rate, out_ack, ovr_clr,
    output cen_in, cen_out, phase, out_valid, overrun, busy
  );

  modport master (
    output enable, cfg_we, cfg_div, cfg_rate, out_ack, ovr_clr,
    input  cen_in, cen_out, phase, out_valid, overrun, busy
  );
endinterface

// File: rtl/jt12_decim_ctrl.sv
// Clock-enable generator for a decimator: input-rate strobe from a clk divider,
// output-rate strobe every cfg_rate+1 input strobes, plus sample valid/overrun tracking.
module jt12_decim_ctrl #(
  parameter int unsigned DIVW     = 8,
  parameter int unsigned RATEW    = 4,
  parameter int unsigned DIV_RST  = 0,
  parameter int unsigned RATE_RST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  jt12_decim_ctrl_if.slave   bus
);

  logic [DIVW-1:0]  div_q,   div_d;
  logic [RATEW-1:0] rate_q,  rate_d;
  logic [DIVW-1:0]  pdiv_q,  pdiv_d;
  logic [RATEW-1:0] prate_q, prate_d;
  logic             busy_q,  busy_d;
  logic [DIVW-1:0]  cnt_q,   cnt_d;
  logic [RATEW-1:0] phase_q, phase_d;
  logic             cen_in_q,  cen_in_d;
  logic             wrap_q,    wrap_d;
  logic             cen_out_q, cen_out_d;
  logic             valid_q,   valid_d;
  logic             ovr_q,     ovr_d;
  logic             tick;
  logic             apply;

  always_comb begin
    div_d     = div_q;
    rate_d    = rate_q;
    pdiv_d    = pdiv_q;
    prate_d   = prate_q;
    busy_d    = busy_q;
    cnt_d     = '0;
    phase_d   = '0;
    cen_in_d  = 1'b0;
    wrap_d    = 1'b0;
    cen_out_d = wrap_q;
    tick      = bus.enable && (cnt_q == div_q);
    apply     = busy_q && (cen_out_q || !bus.enable);

    if (bus.enable) begin
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      cen_in_d = tick;
      phase_d  = phase_q;
      if (tick) begin
        phase_d = (phase_q == rate_q) ? '0 : phase_q + 1'b1;
        wrap_d  = (phase_q == rate_q);
      end
    end

    // New settings take effect on a clean boundary: counters restart at 0
    // and the strobe that would coincide with the switch is dropped.
    if (apply) begin
      div_d    = pdiv_q;
      rate_d   = prate_q;
      busy_d   = 1'b0;
      cnt_d    = '0;
      phase_d  = '0;
      cen_in_d = 1'b0;
      wrap_d   = 1'b0;
    end

    if (bus.cfg_we) begin
      pdiv_d  = bus.cfg_div;
      prate_d = bus.cfg_rate;
      busy_d  = 1'b1;
    end

    valid_d = cen_out_q | (valid_q & ~bus.out_ack);
    ovr_d   = (cen_out_q & valid_q & ~bus.out_ack) | (ovr_q & ~bus.ovr_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= DIVW'(DIV_RST);
      rate_q    <= RATEW'(RATE_RST);
      pdiv_q    <= '0;
      prate_q   <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      phase_q   <= '0;
      cen_in_q  <= 1'b0;
      wrap_q    <= 1'b0;
      cen_out_q <= 1'b0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      rate_q    <= rate_d;
      pdiv_q    <= pdiv_d;
      prate_q   <= prate_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      cen_in_q  <= cen_in_d;
      wrap_q    <= wrap_d;
      cen_out_q <= cen_out_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.cen_in    = cen_in_q;
  assign bus.cen_out   = cen_out_q;
  assign bus.phase     = phase_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_jt12_decim_ctrl.sv
// Directed bench for jt12_decim_ctrl: strobe cadence, config handoff,
// enable drop, sample handshake/overrun and mid-run reset.
module tb_jt12_decim_ctrl;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_pass;

  jt12_decim_ctrl_if #(.DIVW(8), .RATEW(4)) bus_if ();

  jt12_decim_ctrl #(
    .DIVW    (8),
    .RATEW   (4),
    .DIV_RST (0),
    .RATE_RST(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {26'd0, bus_if.cen_in, bus_if.cen_out, bus_if.out_valid,
              bus_if.overrun, bus_if.busy, 1'b0}, 32'd0);
    chk({tag, "_phase"}, 32'(bus_if.phase), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.enable   = 1'b0;
    bus_if.cfg_we   = 1'b0;
    bus_if.cfg_div  = '0;
    bus_if.cfg_rate = '0;
    bus_if.out_ack  = 1'b0;
    bus_if.ovr_clr  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Load settings while disabled: captured on one edge, applied on the next.
  task automatic cfg_idle(input logic [7:0] d, input logic [3:0] r);
    bus_if.enable   = 1'b0;
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_div  = d;
    bus_if.cfg_rate = r;
    step();
    chk("cfg_busy_set", 32'(bus_if.busy), 32'd1);
    bus_if.cfg_we = 1'b0;
    step();
    chk("cfg_busy_clr", 32'(bus_if.busy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset values and default cadence (div 0, rate 1)
    do_reset();
    all_zero("reset");
    bus_if.enable = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("def_cen_in_%0d", e), 32'(bus_if.cen_in), 32'd1);
      chk($sformatf("def_cen_out_%0d", e), 32'(bus_if.cen_out),
          32'((e >= 3) && (e % 2 == 1)));
      chk($sformatf("def_phase_%0d", e), 32'(bus_if.phase), 32'(e % 2));
    end
    // Wrap happened on edge 8; its cen_out must still appear after disable
    bus_if.enable = 1'b0;
    step();
    chk("dis_cen_out_pending", 32'(bus_if.cen_out), 32'd1);
    chk("dis_cen_in_off", 32'(bus_if.cen_in), 32'd0);
    chk("dis_phase0", 32'(bus_if.phase), 32'd0);
    step();
    chk("dis_cen_out_off", 32'(bus_if.cen_out), 32'd0);

    // Rate change mid-period: div 3, rate 5
    do_reset();
    bus_if.enable = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      bus_if.cfg_we   = (e == 2);
      bus_if.cfg_div  = 8'd3;
      bus_if.cfg_rate = 4'd5;
      step();
      if (e == 2) chk("rc_busy_e2", 32'(bus_if.busy), 32'd1);
      if (e == 3) begin
        chk("rc_busy_e3", 32'(bus_if.busy), 32'd1);
        chk("rc_cen_out_e3", 32'(bus_if.cen_out), 32'd1);
      end
      if (e == 4) begin
        chk("rc_busy_e4", 32'(bus_if.busy), 32'd0);
        chk("rc_cen_in_e4", 32'(bus_if.cen_in), 32'd0);
      end
      if (e >= 5) begin
        chk($sformatf("rc_cen_in_%0d", e), 32'(bus_if.cen_in),
            32'((e >= 8) && ((e - 8) % 4 == 0)));
        chk($sformatf("rc_cen_out_%0d", e), 32'(bus_if.cen_out),
            32'((e == 29) || (e == 53)));
      end
    end
    bus_if.cfg_we = 1'b0;

    // Handshake and overrun with div 1, rate 1 (cen_out every 4 clk)
    do_reset();
    cfg_idle(8'd1, 4'd1);
    bus_if.enable = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      bus_if.out_ack = (e == 8) || (e == 12) || (e == 16) || (e == 26);
      bus_if.ovr_clr = (e == 23) || (e == 30) || (e == 31);
      step();
      if (e >= 6) begin
        chk($sformatf("hs_valid_%0d", e), 32'(bus_if.out_valid),
            32'((e >= 18) || (e % 4 == 2) || (e % 4 == 3)));
        chk($sformatf("hs_overrun_%0d", e), 32'(bus_if.overrun),
            32'((e == 22) || (e == 30)));
      end
    end
    bus_if.out_ack = 1'b0;
    bus_if.ovr_clr = 1'b0;

    // Enable drop at phase 3 with a pending write
    do_reset();
    cfg_idle(8'd0, 4'd5);
    bus_if.enable = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("en_phase_%0d", e), 32'(bus_if.phase), 32'(e));
    end
    bus_if.enable   = 1'b0;
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_div  = 8'd2;
    bus_if.cfg_rate = 4'd2;
    step();
    chk("en_drop_phase", 32'(bus_if.phase), 32'd0);
    chk("en_drop_busy", 32'(bus_if.busy), 32'd1);
    chk("en_drop_cen_in", 32'(bus_if.cen_in), 32'd0);
    bus_if.cfg_we = 1'b0;
    step();
    chk("en_apply_busy", 32'(bus_if.busy), 32'd0);
    chk("en_idle_strobes", {30'd0, bus_if.cen_in, bus_if.cen_out}, 32'd0);
    step();
    chk("en_idle_strobes2", {30'd0, bus_if.cen_in, bus_if.cen_out}, 32'd0);
    bus_if.enable = 1'b1;
    for (int e = 7; e <= 16; e++) begin
      step();
      chk($sformatf("en_cen_in_%0d", e), 32'(bus_if.cen_in),
          32'((e == 9) || (e == 12) || (e == 15)));
      chk($sformatf("en_cen_out_%0d", e), 32'(bus_if.cen_out), 32'(e == 16));
      chk($sformatf("en_phase_r_%0d", e), 32'(bus_if.phase),
          (e < 9) ? 32'd0 : (e < 12) ? 32'd1 : (e < 15) ? 32'd2 : 32'd0);
    end

    // Reset in the middle of operation
    do_reset();
    bus_if.enable = 1'b1;
    repeat (4) step();
    chk("mr_valid_e4", 32'(bus_if.out_valid), 32'd1);
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_div  = 8'd5;
    bus_if.cfg_rate = 4'd3;
    step();
    chk("mr_busy_e5", 32'(bus_if.busy), 32'd1);
    chk("mr_valid_e5", 32'(bus_if.out_valid), 32'd1);
    bus_if.cfg_we = 1'b0;
    rst_n = 1'b0;
    step();
    all_zero("mr_reset");
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("mr_cen_in_%0d", e), 32'(bus_if.cen_in), 32'd1);
      chk($sformatf("mr_cen_out_%0d", e), 32'(bus_if.cen_out), 32'(e == 3));
      chk($sformatf("mr_busy_%0d", e), 32'(bus_if.busy), 32'd0);
    end
    chk("mr_phase_e3", 32'(bus_if.phase), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
